da_lut_loader: RTL
==================

# da_lut_loader

Upstream configuration stage for `fir_filter`. It accepts the 64 signed 16-bit FIR coefficients as a stream and computes the 2048-entry distributed-arithmetic partial-sum table: 8 groups of 256 entries, each entry the sum of the group's coefficients selected by the address bits. It drives the filter's `CIN`/`CADDR`/`CLOAD` load port directly, replacing software precomputation.

## Interface
Parameters:
- `HOLD_CYCLES`, 192: `clk_fast` cycles each table entry is held on `CIN`/`CADDR`. Matches the fast/slow clock ratio so the filter samples each entry once on `clk_slow`. Minimum 1.

Ports:
- `clk_fast`  in  1: the block's only clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `coef_in`  in  16: signed coefficient; coefficient n is the n-th accepted.
- `coef_valid`  in  1: `coef_in` is valid.
- `coef_ready`  out  1: block can accept a coefficient.
- `CIN`  out  20: signed partial sum to the filter table.
- `CADDR`  out  11: table address; {group[2:0], index[7:0]}.
- `CLOAD`  out  1: table load enable; high for the whole generation pass.
- `busy`  out  1: high in COLLECT or GEN.
- `done`  out  1: one-cycle pulse when the last entry's hold period ends.

## Operation
- State IDLE, on reset:
  - Outputs: `coef_ready`=1, `CLOAD`=0, `CIN`=0, `CADDR`=0, `busy`=0, `done`=0.
  - Coefficient counter is cleared.
- IDLE→COLLECT on the first accepted beat.
- Accepting coefficients:
  - A beat is accepted when `coef_valid`&&`coef_ready`. It is written to coef[cnt] and cnt increments.
  - The 64th accept moves COLLECT→GEN. `coef_ready` drops on the next cycle.
- GEN walks groups k=0..7, step g=0..255:
  - Index is gray(g)=g^(g>>1). `CADDR`={k, gray(g)}.
  - g=0: acc=0.
  - g>0: let b = trailing-zero count of g. If bit b of gray(g) is 1, acc += coef[8k+b]; otherwise acc −= coef[8k+b].
  - Result: entry(k,a) = Σ coef[8k+i] over the set bits i of a, identical to the direct definition.
- Arithmetic:
  - Sums of up to 8 signed 16-bit values fit in 19 bits.
  - acc is 20-bit two's complement, sign-extended, with no saturation or overflow.
- GEN→DONE after entry (7, gray(255)) finishes its hold. In DONE, `CLOAD`=0 and `coef_ready`=1.
- DONE→COLLECT on the next accepted beat (reload). The stored coefficient set is replaced from index 0.
- `coef_ready`=0 throughout GEN. Valid beats presented then are not accepted and must be held by the source.

## Timing
- After the 64th accept, the next cycle shows `CLOAD`=1, `CADDR`=0, `CIN`=0.
- Each entry is stable for exactly `HOLD_CYCLES` cycles. Address and data change together on one edge.
- GEN lasts exactly 2048×`HOLD_CYCLES` cycles.
- On the cycle after the final hold:
  - `CLOAD`=0 and `done`=1 for one cycle.
  - `CIN`/`CADDR` keep their last values.
- Collection takes 64 cycles minimum with `coef_valid` held high.
- `reset` in any state, including mid-GEN, returns to IDLE on the next edge with reset output values and no `done` pulse. The partial table already loaded is not repaired.
- `reset` has priority over a simultaneous accept.

## Configuration
- `LUT_CHECKSUM_EN` defined:
  - Adds output `checksum` (32-bit).
  - Sign-extended sum of every `CIN` value presented, counted once per entry.
  - Cleared on reset and on entering GEN; valid when `done` pulses.
  - Lets the bench and software cross-check the table.
- Not defined: the port and accumulator are absent and behaviour is otherwise identical.

## Structure
- Shared package `fir_pkg` holds:
  - constants NTAPS=64, DA_GROUP=8, LUT_DEPTH=2048, COEF_W=16, CIN_W=20, CADDR_W=11;
  - the loader state enum.
- Sub-module `da_gray_step` (combinational): g[7:0] → gray index[7:0], changed bit b[2:0], and add/subtract flag.
- Coefficient storage is a 64×16 register array.

## Test plan
- All 64 coefficients = 1, `HOLD_CYCLES`=1:
  - 2048 writes, each `CIN`=popcount(`CADDR`[7:0]). Entry 0x0FF=8; `done` pulses on cycle 2049 after GEN entry.
- coef[0]=−32768, all others 0:
  - Odd addresses in group 0 carry 0xF8000; every other entry is 0.
- All coefficients = 32767:
  - Index 0xFF of each group = 262136 (0x3FFF8); no wrap.
  - Random coefficients checked against the direct per-address sum for all 2048 entries.
- Backpressure:
  - `coef_valid` held high across GEN: `coef_ready`=0, no extra accepts.
  - Reload after `done` regenerates the table with new values.
- `reset` asserted at entry 700 of GEN: next cycle `CLOAD`=0, `busy`=0, no `done`; a fresh 64-beat load completes normally.
- `HOLD_CYCLES`=192: each `CADDR` value is stable for exactly 192 cycles. With `LUT_CHECKSUM_EN`, `checksum` = 128×Σcoef at `done`.

Source files
------------

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR constants and DA table loader state encoding
package fir_pkg;

  localparam int NTAPS     = 64;
  localparam int DA_GROUP  = 8;
  localparam int LUT_DEPTH = 2048;
  localparam int COEF_W    = 16;
  localparam int CIN_W     = 20;
  localparam int CADDR_W   = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_GEN,
    ST_DONE
  } loader_state_e;

endpackage

// File: rtl/da_gray_step.sv
// rtl/da_gray_step.sv - gray-code walk step: index, changed bit and add/subtract flag
module da_gray_step (
  input  logic [7:0] g_i,
  output logic [7:0] idx_o,
  output logic [2:0] bit_o,
  output logic       add_o
);

  // Moving from g-1 to g flips exactly the bit at g's trailing-zero position;
  // the new gray bit tells whether that coefficient entered or left the sum.
  always_comb begin
    idx_o = g_i ^ (g_i >> 1);
    bit_o = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (g_i[i]) begin
        bit_o = 3'(i);
      end
    end
    add_o = idx_o[bit_o];
  end

endmodule

// File: rtl/da_lut_loader.sv
// rtl/da_lut_loader.sv - collects 64 FIR coefficients and streams the DA partial-sum table (optional LUT_CHECKSUM_EN)
module da_lut_loader
  import fir_pkg::*;
#(
  parameter int HOLD_CYCLES = 192
) (
  input  logic               clk_fast,
  input  logic               reset,
  input  logic [COEF_W-1:0]  coef_in,
  input  logic               coef_valid,
  output logic               coef_ready,
  output logic [CIN_W-1:0]   CIN,
  output logic [CADDR_W-1:0] CADDR,
  output logic               CLOAD,
  output logic               busy,
  output logic               done
`ifdef LUT_CHECKSUM_EN
  ,
  output logic [31:0]        checksum
`endif
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  loader_state_e       state_q, state_d;
  logic [5:0]          cnt_q;
  logic [COEF_W-1:0]   coef_q [NTAPS];
  logic [2:0]          grp_q;
  logic [7:0]          step_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [CIN_W-1:0]    cin_q;
  logic [CADDR_W-1:0]  caddr_q;
  logic                done_q;

  logic                accept;
  logic                last_beat;
  logic                hold_end;
  logic                last_entry;
  logic [7:0]          step_nx;
  logic [2:0]          grp_nx;
  logic [7:0]          idx_nx;
  logic [2:0]          bit_nx;
  logic                add_nx;
  logic [COEF_W-1:0]   coef_sel;
  logic [CIN_W-1:0]    coef_ext;
  logic [CIN_W-1:0]    cin_nx;

  assign accept     = coef_valid && (state_q != ST_GEN);
  assign last_beat  = accept && (state_q == ST_COLLECT) && (cnt_q == 6'd63);
  assign hold_end   = (state_q == ST_GEN) && (hold_q == HOLD_W'(HOLD_CYCLES - 1));
  assign last_entry = (grp_q == 3'd7) && (step_q == 8'hFF);

  assign coef_ready = (state_q != ST_GEN);
  assign CLOAD      = (state_q == ST_GEN);
  assign busy       = (state_q == ST_COLLECT) || (state_q == ST_GEN);
  assign done       = done_q;
  assign CIN        = cin_q;
  assign CADDR      = caddr_q;

  // Next table entry: step wraps 255->0 into the following group, where the
  // running sum restarts from zero instead of being updated incrementally.
  assign step_nx = step_q + 8'd1;
  assign grp_nx  = grp_q + {2'b00, (step_q == 8'hFF)};

  da_gray_step u_gray_step (
    .g_i   (step_nx),
    .idx_o (idx_nx),
    .bit_o (bit_nx),
    .add_o (add_nx)
  );

  assign coef_sel = coef_q[{grp_nx, bit_nx}];
  assign coef_ext = {{(CIN_W - COEF_W){coef_sel[COEF_W-1]}}, coef_sel};
  assign cin_nx   = (step_nx == 8'd0) ? '0 :
                    add_nx ? (cin_q + coef_ext) : (cin_q - coef_ext);

  // State register.
  always_ff @(posedge clk_fast) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: collect 64 beats, generate 2048 held entries, then wait for reload.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (accept) state_d = ST_COLLECT;
      ST_COLLECT:       if (last_beat) state_d = ST_GEN;
      ST_GEN:           if (hold_end && last_entry) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Coefficient storage; a beat lost to a simultaneous reset is never written.
  always_ff @(posedge clk_fast) begin
    if (!reset && accept) begin
      coef_q[cnt_q] <= coef_in;
    end
  end

`ifdef LUT_CHECKSUM_EN
  logic [31:0] checksum_q;
  assign checksum = checksum_q;
`endif

  // Beat counter, table walk, hold timer and load-port registers.
  always_ff @(posedge clk_fast) begin
    if (reset) begin
      cnt_q   <= '0;
      grp_q   <= '0;
      step_q  <= '0;
      hold_q  <= '0;
      cin_q   <= '0;
      caddr_q <= '0;
      done_q  <= 1'b0;
`ifdef LUT_CHECKSUM_EN
      checksum_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        cnt_q <= cnt_q + 6'd1;
      end
      if (last_beat) begin
        grp_q   <= '0;
        step_q  <= '0;
        hold_q  <= '0;
        cin_q   <= '0;
        caddr_q <= '0;
`ifdef LUT_CHECKSUM_EN
        checksum_q <= '0;
`endif
      end else if (state_q == ST_GEN) begin
        if (hold_end) begin
          hold_q <= '0;
          if (last_entry) begin
            done_q <= 1'b1;
          end else begin
            step_q  <= step_nx;
            grp_q   <= grp_nx;
            cin_q   <= cin_nx;
            caddr_q <= {grp_nx, idx_nx};
`ifdef LUT_CHECKSUM_EN
            checksum_q <= checksum_q + {{(32 - CIN_W){cin_nx[CIN_W-1]}}, cin_nx};
`endif
          end
        end else begin
          hold_q <= hold_q + HOLD_W'(1);
        end
      end
    end
  end

endmodule
